// File: rtl/fc_engine_arbiter.sv
// Round-robin arbiter sharing one FC layer engine between two requesters:
// muxes operands, pulses start, watches for done under a timeout, returns the result.
module fc_engine_arbiter #(
    parameter int IN_SIZE  = 16,
    parameter int OUT_SIZE = 8,
    parameter int W        = 8,
    parameter int TIMEOUT  = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req0,
    input  logic                           req1,
    input  logic [W*IN_SIZE-1:0]           in0_flat,
    input  logic [W*IN_SIZE-1:0]           in1_flat,
    input  logic [W*OUT_SIZE*IN_SIZE-1:0]  w0_flat,
    input  logic [W*OUT_SIZE*IN_SIZE-1:0]  w1_flat,
    input  logic [W*OUT_SIZE-1:0]          b0_flat,
    input  logic [W*OUT_SIZE-1:0]          b1_flat,
    output logic                           ack0,
    output logic                           ack1,
    output logic                           err,
    output logic [W*OUT_SIZE-1:0]          result_flat,
    output logic                           result_id,
    output logic                           busy,
    output logic                           eng_start,
    output logic [W*IN_SIZE-1:0]           eng_in_flat,
    output logic [W*OUT_SIZE*IN_SIZE-1:0]  eng_w_flat,
    output logic [W*OUT_SIZE-1:0]          eng_b_flat,
    input  logic [W*OUT_SIZE-1:0]          eng_out_flat,
    input  logic                           eng_done
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  r_state;
    logic                    r_grant;
    logic                    r_last_grant;
    logic [TW-1:0]           r_timer;
    logic                    r_armed;
    logic                    r_ack0;
    logic                    r_ack1;
    logic                    r_err;
    logic [W*OUT_SIZE-1:0]   r_result;
    logic                    r_result_id;
    logic                    r_busy;
    logic                    r_eng_start;

    logic                    w_pick;
    logic                    w_complete;
    logic                    w_expired;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_pick = 1'b0;
        if (req0 && req1) begin
            w_pick = ~r_last_grant;
        end else if (req1) begin
            w_pick = 1'b1;
        end
    end

    assign w_complete = r_armed && eng_done;
    assign w_expired  = (r_timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_timer      <= '0;
            r_armed      <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err        <= 1'b0;
            r_result     <= '0;
            r_result_id  <= 1'b0;
            r_busy       <= 1'b0;
            r_eng_start  <= 1'b0;
        end else begin
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_eng_start <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_grant     <= w_pick;
                        r_eng_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    r_timer <= '0;
                    r_armed <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done level left over from the previous op is ignored until it drops once.
                    if (!eng_done) begin
                        r_armed <= 1'b1;
                    end
                    if (w_complete) begin
                        r_result    <= eng_out_flat;
                        r_result_id <= r_grant;
                        r_err       <= 1'b0;
                        r_ack0      <= ~r_grant;
                        r_ack1      <= r_grant;
                        r_state     <= ST_DONE;
                    end else if (w_expired) begin
                        r_result_id <= r_grant;
                        r_err       <= 1'b1;
                        r_ack0      <= ~r_grant;
                        r_ack1      <= r_grant;
                        r_state     <= ST_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_last_grant <= r_grant;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign err         = r_err;
    assign result_flat = r_result;
    assign result_id   = r_result_id;
    assign busy        = r_busy;
    assign eng_start   = r_eng_start;

    assign eng_in_flat = r_grant ? in1_flat : in0_flat;
    assign eng_w_flat  = r_grant ? w1_flat  : w0_flat;
    assign eng_b_flat  = r_grant ? b1_flat  : b0_flat;

endmodule

// File: doc/fc_engine_arbiter.md
# fc_engine_arbiter

Shares one fully-connected layer engine (an `fc_layer1_flattened` instance, flattened-vector interface) between two requesters. It arbitrates round-robin and muxes the winner's input vector, weights and biases onto the engine. It issues a one-cycle engine start, waits for engine completion under a timeout watchdog, and returns the registered result with a one-cycle acknowledge. It sits between the layer-level control logic and the single physical FC datapath.

## Interface
- IN_SIZE, 16, input vector length
- OUT_SIZE, 8, output vector length
- W, 8, element width (signed)
- TIMEOUT, 256, max cycles in WAIT before abort (>=2)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req0, req1  in  1 each  request level; held until own ack
- in0_flat, in1_flat  in  W*IN_SIZE  requester input vectors; held stable while req high
- w0_flat, w1_flat  in  W*OUT_SIZE*IN_SIZE  requester weight matrices
- b0_flat, b1_flat  in  W*OUT_SIZE  requester biases
- ack0, ack1  out  1 each  one-cycle completion pulse
- err  out  1  high with ack when the op timed out
- result_flat  out  W*OUT_SIZE  last captured engine output
- result_id  out  1  requester that owns result_flat
- busy  out  1  high in any state other than IDLE
- eng_start  out  1  engine start pulse
- eng_in_flat, eng_w_flat, eng_b_flat  out  engine operand widths  muxed operands of current grant
- eng_out_flat  in  W*OUT_SIZE  engine result
- eng_done  in  1  engine completion (level or pulse)

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE, exit condition: leaves only when at least one req is high.
  - Single req: that requester is granted.
  - Both high: the requester not equal to last_grant is granted.
  - On leaving: latch grant, go START.
- START: eng_start=1 for exactly this cycle. Clear timer and armed. Go WAIT.
- WAIT, per cycle:
  - eng_done==0 sets armed.
  - Completion = armed && eng_done. On completion: result_flat<=eng_out_flat, result_id<=grant, err<=0, go DONE.
  - The armed rule makes a done level held over from the previous op invisible.
  - Otherwise timer increments. If timer==TIMEOUT-1 with no completion: err<=1, result_flat unchanged, result_id<=grant, go DONE.
- DONE: ack[grant]=1 for this cycle only, last_grant<=grant, go IDLE.
- Operand mux: eng_*_flat driven from the grant register in every state, including IDLE (the last grant). Operands change only when a new grant is latched.
- A req still high when IDLE is re-entered counts as a new request. Requesters drop req on the edge at which they see ack.
- err holds until the next ack. result_flat and result_id hold until the next completion or timeout.
- No arithmetic in this block. Widths pass through unchanged.

## Timing
- Reset values: state IDLE, last_grant=1 (req0 wins the first tie), grant=0, timer=0, armed=0. All outputs 0, including result_flat, result_id, err, ack*, busy and eng_start.
- Reset mid-operation (any state): immediate return to IDLE with reset values. No ack is issued. The engine is not otherwise notified.
- Request timing: req sampled high at edge k in IDLE gives START in cycle k+1 and WAIT from k+2.
- Completion timing: if completion is seen at edge m, DONE (ack) occupies cycle m+1 and IDLE cycle m+2.
- Minimum request-to-ack latency: 4 cycles plus engine latency.
- Back-to-back: next START no earlier than 2 cycles after ack.
- Timeout: ack with err occurs exactly TIMEOUT+1 cycles after the eng_start cycle.

## Test plan
- Single request, req0 only:
  - Stimulus: in0 = 1..16; weights per row repeat 1,1,-1,0; bias_i = -14+4i.
  - Response: one ack0, err=0, result_id=0, result neuron i = 10+4i (10..38). eng_start high exactly one cycle.
- Simultaneous first request, req0 and req1 together after reset:
  - Stimulus: req1 uses the same data with biases 0.
  - Response: req0 served first (10+4i). req1 served next, all neurons 24, result_id=1.
- Fairness: req0 and req1 held continuously for 6 ops, each re-asserted right after its ack. Grants must alternate 0,1,0,1,0,1.
- Timeout: stub engine with eng_done tied 0, TIMEOUT=16.
  - Response: ack0 with err=1 exactly 17 cycles after eng_start, result_flat unchanged from the previous op. A following good op clears err.
- Stale done: stub engine holding eng_done=1 through START, dropping it 3 cycles, then raising it. The block must not complete before the re-rise; result is captured at the re-rise.
- Reset mid-WAIT: assert reset for one cycle during WAIT.
  - Response: outputs 0, no ack, busy=0. A subsequent req1 completes normally with correct data.
